// File: rtl/disk_loader_dma_pkg.sv
// rtl/disk_loader_dma_pkg.sv - shared encodings and device sizes for the disk loader DMA
// Holds the direction encoding, the FSM state type and the default disk and
// memory word counts shared with the disk and memory models.
package disk_loader_dma_pkg;

    localparam logic DIR_LOAD = 1'b0;   // disk -> memory
    localparam logic DIR_SAVE = 1'b1;   // memory -> disk

    localparam int DISK_SIZE_DEF = 150;
    localparam int MEM_SIZE_DEF  = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

endpackage

// File: rtl/disk_loader_dma_xfer_bounds_check.sv
// rtl/disk_loader_dma_xfer_bounds_check.sv - combinational range check for a transfer command
// Ports:
//   dir       transfer direction (selects which device is source / destination)
//   src_addr  first source word address
//   dst_addr  first destination word address
//   length    number of words
//   reject    1 when either window runs past the end of its device
module disk_loader_dma_xfer_bounds_check
    import disk_loader_dma_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 16,
    parameter int DISK_SIZE = DISK_SIZE_DEF,
    parameter int MEM_SIZE  = MEM_SIZE_DEF
) (
    input  logic              dir,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              reject
);

    localparam logic [ADDR_W:0] DISK_LIM = (ADDR_W+1)'(DISK_SIZE);
    localparam logic [ADDR_W:0] MEM_LIM  = (ADDR_W+1)'(MEM_SIZE);

    logic [ADDR_W:0] len_ext;
    logic [ADDR_W:0] src_end;
    logic [ADDR_W:0] dst_end;
    logic [ADDR_W:0] src_lim;
    logic [ADDR_W:0] dst_lim;

    // One extra bit so that an address sum that wraps ADDR_W is still seen
    // as beyond the device rather than as a small in-range address.
    always_comb begin
        len_ext = (ADDR_W+1)'(length);
        src_end = {1'b0, src_addr} + len_ext;
        dst_end = {1'b0, dst_addr} + len_ext;
        src_lim = (dir == DIR_SAVE) ? MEM_LIM  : DISK_LIM;
        dst_lim = (dir == DIR_SAVE) ? DISK_LIM : MEM_LIM;
        reject  = (src_end > src_lim) || (dst_end > dst_lim);
    end

endmodule

// File: rtl/disk_loader_dma.sv
// rtl/disk_loader_dma.sv - block copy engine between the disk word array and main memory
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   start, dir, src_addr, dst_addr,    command from the control unit (sampled in IDLE)
//   length
//   busy, done, err                    status: in progress, completion pulse, reject pulse
//   disk_addr, disk_we, disk_wdata,    disk port (read data arrives on negedge)
//   disk_rdata
//   mem_addr, mem_we, mem_wdata,       memory port (read data arrives on negedge)
//   mem_rdata
module disk_loader_dma
    import disk_loader_dma_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 16,
    parameter int DISK_SIZE = DISK_SIZE_DEF,
    parameter int MEM_SIZE  = MEM_SIZE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              dir,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] disk_addr,
    output logic              disk_we,
    output logic [DATA_W-1:0] disk_wdata,
    input  logic [DATA_W-1:0] disk_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state, state_n;
    logic              dir_q, dir_n;
    logic [ADDR_W-1:0] dst_q, dst_n;
    logic [LEN_W-1:0]  len_q, len_n;
    logic [LEN_W-1:0]  rd_cnt, rd_cnt_n;
    logic [LEN_W-1:0]  wr_cnt, wr_cnt_n;
    logic [ADDR_W-1:0] disk_addr_n, mem_addr_n;
    logic              disk_we_n, mem_we_n, err_n;
    logic [ADDR_W-1:0] wr_addr;
    logic              reject;

    disk_loader_dma_xfer_bounds_check #(
        .ADDR_W    (ADDR_W),
        .LEN_W     (LEN_W),
        .DISK_SIZE (DISK_SIZE),
        .MEM_SIZE  (MEM_SIZE)
    ) u_bounds (
        .dir      (dir),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .length   (length),
        .reject   (reject)
    );

    // The source device registers its read data on negedge, so the word read
    // in one cycle is already on its rdata bus for the next cycle's write.
    assign disk_wdata = mem_rdata;
    assign mem_wdata  = disk_rdata;

    assign busy = (state == XFER) || (state == DRAIN);
    assign done = (state == FIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dir_q     <= DIR_LOAD;
            dst_q     <= '0;
            len_q     <= '0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            disk_addr <= '0;
            mem_addr  <= '0;
            disk_we   <= 1'b0;
            mem_we    <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            dir_q     <= dir_n;
            dst_q     <= dst_n;
            len_q     <= len_n;
            rd_cnt    <= rd_cnt_n;
            wr_cnt    <= wr_cnt_n;
            disk_addr <= disk_addr_n;
            mem_addr  <= mem_addr_n;
            disk_we   <= disk_we_n;
            mem_we    <= mem_we_n;
            err       <= err_n;
        end
    end

    always_comb begin
        state_n     = state;
        dir_n       = dir_q;
        dst_n       = dst_q;
        len_n       = len_q;
        rd_cnt_n    = rd_cnt;
        wr_cnt_n    = wr_cnt;
        disk_addr_n = disk_addr;
        mem_addr_n  = mem_addr;
        disk_we_n   = 1'b0;
        mem_we_n    = 1'b0;
        err_n       = 1'b0;
        wr_addr     = dst_q + ADDR_W'(wr_cnt);

        case (state)
            IDLE: begin
                if (start) begin
                    if (reject) begin
                        err_n = 1'b1;
                    end else if (length == '0) begin
                        state_n = FIN;
                    end else begin
                        dir_n    = dir;
                        dst_n    = dst_addr;
                        len_n    = length;
                        rd_cnt_n = '0;
                        wr_cnt_n = '0;
                        if (dir == DIR_SAVE) mem_addr_n  = src_addr;
                        else                 disk_addr_n = src_addr;
                        state_n  = XFER;
                    end
                end
            end

            // Each cycle schedules the write of the word read this cycle for
            // the next cycle, and advances the read address unless this was
            // the last read (the source address then simply holds).
            XFER: begin
                if (dir_q == DIR_SAVE) begin
                    disk_addr_n = wr_addr;
                    disk_we_n   = 1'b1;
                end else begin
                    mem_addr_n  = wr_addr;
                    mem_we_n    = 1'b1;
                end
                wr_cnt_n = wr_cnt + LEN_W'(1);
                if (rd_cnt == len_q - LEN_W'(1)) begin
                    state_n = DRAIN;
                end else begin
                    rd_cnt_n = rd_cnt + LEN_W'(1);
                    if (dir_q == DIR_SAVE) mem_addr_n  = mem_addr + ADDR_W'(1);
                    else                   disk_addr_n = disk_addr + ADDR_W'(1);
                end
            end

            DRAIN: state_n = FIN;

            FIN: state_n = IDLE;

            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_disk_loader_dma.sv
// tb/tb_disk_loader_dma.sv - directed self-checking bench for disk_loader_dma
module tb_disk_loader_dma;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        dir;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] length;
    logic        busy, done, err;
    logic [31:0] disk_addr, disk_wdata, disk_rdata;
    logic        disk_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    int passed = 0;
    int total  = 0;

    logic [31:0] disk_arr [0:149];
    logic [31:0] mem_arr  [0:1023];
    logic        fill;
    logic        pk_en;
    logic [31:0] pk_addr, pk_data;

    always #5 clk = ~clk;

    disk_loader_dma dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dir        (dir),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .disk_addr  (disk_addr),
        .disk_we    (disk_we),
        .disk_wdata (disk_wdata),
        .disk_rdata (disk_rdata),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    function automatic logic [31:0] dpat(input int i);
        return 32'hD15C_0000 | 32'(i);
    endfunction

    function automatic logic [31:0] mpat(input int i);
        return 32'h3E30_0000 | 32'(i);
    endfunction

    // Disk and memory models: read data and writes both on negedge, so a
    // write uses the read data from the previous cycle.
    always @(negedge clk) begin
        if (fill) begin
            for (int i = 0; i < 150; i++)  disk_arr[i] <= dpat(i);
            for (int i = 0; i < 1024; i++) mem_arr[i]  <= mpat(i);
        end else begin
            if (pk_en) mem_arr[pk_addr[9:0]] <= pk_data;
            if (disk_we && disk_addr < 32'd150)  disk_arr[disk_addr[7:0]] <= disk_wdata;
            if (mem_we  && mem_addr  < 32'd1024) mem_arr[mem_addr[9:0]]   <= mem_wdata;
        end
        disk_rdata <= (disk_addr < 32'd150)  ? disk_arr[disk_addr[7:0]] : 32'h0;
        mem_rdata  <= (mem_addr  < 32'd1024) ? mem_arr[mem_addr[9:0]]   : 32'h0;
    end

    task automatic issue(input logic d, input logic [31:0] s, input logic [31:0] t, input logic [15:0] l);
        @(posedge clk); #1;
        start = 1'b1; dir = d; src_addr = s; dst_addr = t; length = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic poke_mem(input logic [31:0] a, input logic [31:0] d);
        pk_en = 1'b1; pk_addr = a; pk_data = d;
        @(negedge clk); #1;
        pk_en = 1'b0;
    endtask

    task automatic observe(input int max_cyc, output int done_at, output int busy_n,
                           output int mwe_n, output int dwe_n, output int err_n,
                           output int err_at, output bit order_ok);
        logic [31:0] last_m, last_d;
        bit have_m, have_d;
        done_at = -1; busy_n = 0; mwe_n = 0; dwe_n = 0; err_n = 0; err_at = -1;
        order_ok = 1'b1; have_m = 1'b0; have_d = 1'b0; last_m = '0; last_d = '0;
        for (int c = 0; c < max_cyc; c++) begin
            if (busy) busy_n++;
            if (mem_we) begin
                if (have_m && mem_addr !== last_m + 32'd1) order_ok = 1'b0;
                last_m = mem_addr; have_m = 1'b1; mwe_n++;
            end
            if (disk_we) begin
                if (have_d && disk_addr !== last_d + 32'd1) order_ok = 1'b0;
                last_d = disk_addr; have_d = 1'b1; dwe_n++;
            end
            if (err) begin
                err_n++;
                if (err_at < 0) err_at = c;
            end
            if (done) begin
                done_at = c;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; dir = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
        pk_en = 1'b0; pk_addr = '0; pk_data = '0; fill = 1'b1;
        @(negedge clk); #1;
        fill = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({busy, done, err, disk_we, mem_we} !== 5'b0 || disk_addr !== 32'd0 || mem_addr !== 32'd0)
            $display("FAIL reset_outputs: busy=%b done=%b err=%b dwe=%b mwe=%b daddr=%0d maddr=%0d, required all 0",
                     busy, done, err, disk_we, mem_we, disk_addr, mem_addr);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_boot();
        int done_at, busy_n, mwe_n, dwe_n, err_n, err_at, bad;
        bit order_ok;
        issue(1'b0, 32'd0, 32'd0, 16'd47);
        observe(100, done_at, busy_n, mwe_n, dwe_n, err_n, err_at, order_ok);
        total++; if (done_at !== 48) $display("FAIL load_done_cycle: got %0d, required 48", done_at); else passed++;
        total++; if (busy_n !== 48) $display("FAIL load_busy_cycles: got %0d, required 48", busy_n); else passed++;
        total++; if (mwe_n !== 47) $display("FAIL load_mem_we_cycles: got %0d, required 47", mwe_n); else passed++;
        total++; if (dwe_n !== 0 || !order_ok) $display("FAIL load_disk_we_order: dwe=%0d order=%0d, required 0 and 1", dwe_n, order_ok); else passed++;
        bad = 0;
        for (int i = 0; i < 47; i++) if (mem_arr[i] !== dpat(i)) bad++;
        total++; if (bad !== 0) $display("FAIL load_mem_contents: %0d wrong words, required 0", bad); else passed++;
        total++; if (mem_arr[47] !== mpat(47)) $display("FAIL load_mem_past_end: got %h, required %h", mem_arr[47], mpat(47)); else passed++;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL load_idle_after: busy=%b done=%b, required 0 0", busy, done); else passed++;
    endtask

    task automatic test_save();
        int done_at, busy_n, mwe_n, dwe_n, err_n, err_at;
        bit order_ok;
        poke_mem(32'd100, 32'hA);
        poke_mem(32'd101, 32'hB);
        poke_mem(32'd102, 32'hC);
        poke_mem(32'd103, 32'hD);
        issue(1'b1, 32'd100, 32'd120, 16'd4);
        observe(20, done_at, busy_n, mwe_n, dwe_n, err_n, err_at, order_ok);
        total++; if (done_at !== 5) $display("FAIL save_done_cycle: got %0d, required 5", done_at); else passed++;
        total++; if (mwe_n !== 0 || dwe_n !== 4 || !order_ok) $display("FAIL save_we: mwe=%0d dwe=%0d order=%0d, required 0 4 1", mwe_n, dwe_n, order_ok); else passed++;
        total++;
        if (disk_arr[120] !== 32'hA || disk_arr[121] !== 32'hB || disk_arr[122] !== 32'hC || disk_arr[123] !== 32'hD)
            $display("FAIL save_disk_contents: got %h %h %h %h, required a b c d", disk_arr[120], disk_arr[121], disk_arr[122], disk_arr[123]);
        else passed++;
        total++;
        if (disk_arr[119] !== dpat(119) || disk_arr[124] !== dpat(124))
            $display("FAIL save_neighbours: got %h %h, required %h %h", disk_arr[119], disk_arr[124], dpat(119), dpat(124));
        else passed++;
    endtask

    task automatic test_bounds_reject();
        int done_at, busy_n, mwe_n, dwe_n, err_n, err_at, bad;
        bit order_ok;
        issue(1'b0, 32'd140, 32'd0, 16'd11);
        observe(3, done_at, busy_n, mwe_n, dwe_n, err_n, err_at, order_ok);
        total++; if (err_at !== 0 || err_n !== 1) $display("FAIL reject_disk_err: at=%0d count=%0d, required 0 1", err_at, err_n); else passed++;
        total++; if (busy_n !== 0 || mwe_n !== 0 || dwe_n !== 0 || done_at !== -1)
            $display("FAIL reject_disk_quiet: busy=%0d mwe=%0d dwe=%0d done=%0d, required 0 0 0 -1", busy_n, mwe_n, dwe_n, done_at);
        else passed++;
        issue(1'b1, 32'd1020, 32'd0, 16'd5);
        observe(3, done_at, busy_n, mwe_n, dwe_n, err_n, err_at, order_ok);
        total++; if (err_at !== 0 || busy_n !== 0 || dwe_n !== 0) $display("FAIL reject_mem_err: at=%0d busy=%0d dwe=%0d, required 0 0 0", err_at, busy_n, dwe_n); else passed++;
        issue(1'b0, 32'd140, 32'd600, 16'd10);
        observe(30, done_at, busy_n, mwe_n, dwe_n, err_n, err_at, order_ok);
        total++; if (done_at !== 11 || err_n !== 0 || mwe_n !== 10) $display("FAIL edge_load_timing: done=%0d err=%0d mwe=%0d, required 11 0 10", done_at, err_n, mwe_n); else passed++;
        bad = 0;
        for (int i = 0; i < 10; i++) if (mem_arr[600 + i] !== dpat(140 + i)) bad++;
        total++; if (bad !== 0) $display("FAIL edge_load_contents: %0d wrong words, required 0", bad); else passed++;
    endtask

    task automatic test_zero_length();
        int done_at, busy_n, mwe_n, dwe_n, err_n, err_at;
        bit order_ok;
        issue(1'b0, 32'd5, 32'd7, 16'd0);
        observe(5, done_at, busy_n, mwe_n, dwe_n, err_n, err_at, order_ok);
        total++; if (done_at !== 0 || busy_n !== 0) $display("FAIL zero_done: done=%0d busy=%0d, required 0 0", done_at, busy_n); else passed++;
        total++; if (mwe_n !== 0 || dwe_n !== 0 || err_n !== 0) $display("FAIL zero_no_access: mwe=%0d dwe=%0d err=%0d, required 0 0 0", mwe_n, dwe_n, err_n); else passed++;
        total++; if (disk_addr !== 32'd149 || mem_addr !== 32'd609) $display("FAIL zero_addr_hold: daddr=%0d maddr=%0d, required 149 609", disk_addr, mem_addr); else passed++;
    endtask

    task automatic test_start_while_busy();
        int done_at, busy_n, mwe_n, dwe_n, err_n, err_at, bad;
        bit order_ok;
        issue(1'b0, 32'd10, 32'd200, 16'd5);
        @(posedge clk); #1;
        start = 1'b1; dir = 1'b1; src_addr = 32'd20; dst_addr = 32'd50; length = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        observe(20, done_at, busy_n, mwe_n, dwe_n, err_n, err_at, order_ok);
        total++; if (done_at !== 4 || dwe_n !== 0) $display("FAIL busy_ignore_timing: done=%0d dwe=%0d, required 4 0", done_at, dwe_n); else passed++;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (mem_arr[200 + i] !== dpat(10 + i)) bad++;
            if (disk_arr[50 + i] !== dpat(50 + i)) bad++;
        end
        total++; if (bad !== 0) $display("FAIL busy_ignore_contents: %0d wrong words, required 0", bad); else passed++;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) $display("FAIL busy_ignore_no_restart: busy=%b, required 0", busy); else passed++;
    endtask

    task automatic test_reset_mid_transfer();
        int done_at, busy_n, mwe_n, dwe_n, err_n, err_at, bad;
        bit order_ok;
        issue(1'b0, 32'd30, 32'd500, 16'd10);
        repeat (3) begin
            @(posedge clk); #1;
        end
        #5;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, err, disk_we, mem_we} !== 5'b0 || disk_addr !== 32'd0 || mem_addr !== 32'd0)
            $display("FAIL midreset_outputs: busy=%b done=%b err=%b dwe=%b mwe=%b daddr=%0d maddr=%0d, required all 0",
                     busy, done, err, disk_we, mem_we, disk_addr, mem_addr);
        else passed++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++)  if (mem_arr[500 + i] !== dpat(30 + i)) bad++;
        for (int i = 3; i < 10; i++) if (mem_arr[500 + i] !== mpat(500 + i)) bad++;
        total++; if (bad !== 0) $display("FAIL midreset_partial: %0d wrong words, required 0", bad); else passed++;
        issue(1'b0, 32'd60, 32'd700, 16'd3);
        observe(20, done_at, busy_n, mwe_n, dwe_n, err_n, err_at, order_ok);
        total++; if (done_at !== 4 || mwe_n !== 3 || !order_ok) $display("FAIL midreset_restart: done=%0d mwe=%0d order=%0d, required 4 3 1", done_at, mwe_n, order_ok); else passed++;
        bad = 0;
        for (int i = 0; i < 3; i++) if (mem_arr[700 + i] !== dpat(60 + i)) bad++;
        total++; if (bad !== 0) $display("FAIL midreset_restart_contents: %0d wrong words, required 0", bad); else passed++;
    endtask

    initial begin
        test_reset();
        test_load_boot();
        test_save();
        test_bounds_reject();
        test_zero_length();
        test_start_while_busy();
        test_reset_mid_transfer();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/disk_loader_dma.md
Name: disk_loader_dma

Overview:
- Block-transfer engine between the hard-disk word array and main memory.
- Used by the boot/OS path to copy a program image from disk into memory (LOAD) and to write memory back to disk (SAVE).
- Sits directly on the disk port (addr, we, datain, dataout) and on a memory write/read port, and is commanded by the CPU control unit.
- Moves one 32-bit word per cycle once running.

Parameters:
- DATA_W, 32, word width.
- ADDR_W, 32, disk and memory address width.
- LEN_W, 16, width of the transfer length count.
- DISK_SIZE, 150, number of disk words; used for the bounds check.
- MEM_SIZE, 1024, number of memory words; used for the bounds check.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- dir  in  1  0 = LOAD (disk to mem), 1 = SAVE (mem to disk).
- src_addr  in  ADDR_W  first source word address.
- dst_addr  in  ADDR_W  first destination word address.
- length  in  LEN_W  number of words to move.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse when a command is rejected for bounds.
- disk_addr  out  ADDR_W  disk word address.
- disk_we  out  1  disk write enable.
- disk_wdata  out  DATA_W  data written to disk.
- disk_rdata  in  DATA_W  disk read data; updated on negedge from disk_addr.
- mem_addr  out  ADDR_W  memory word address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  DATA_W  data written to memory.
- mem_rdata  in  DATA_W  memory read data; updated on negedge from mem_addr.

Behaviour:
Reset (asynchronous, on rst_n low):
- State = IDLE.
- busy, done, err, disk_we, mem_we = 0.
- disk_addr, mem_addr = 0; counters = 0.
- Reset mid-transfer takes effect immediately; no further writes occur; the partial copy is left as is.

Write/data path:
- disk_wdata = mem_rdata and mem_wdata = disk_rdata (combinational pass-through; the source already registers its read data on negedge).
- All addresses and write enables are registered.

States: IDLE, XFER, DRAIN, FIN.

IDLE:
- Reject if start=1 and (src_addr+length > source size, or dst_addr+length > destination size). Source/destination size is DISK_SIZE or MEM_SIZE according to dir. Compare at ADDR_W+1 bits so address wrap counts as out of range. On reject: err=1 for one cycle, stay IDLE, no accesses.
- If start=1 and length=0: go to FIN with no accesses.
- Otherwise on start=1: latch dir, src, dst, length; rd_cnt=0, wr_cnt=0; go to XFER, busy=1.

XFER (transfer cycles k = 0..L-1; cycle 0 is the first XFER cycle):
- Source read address = src + k, presented on disk_addr (LOAD) or mem_addr (SAVE).
- Destination write of word k-1 is presented in the same cycle (for k ≥ 1): dst_addr + (k-1) on the other port's address, its we = 1, data = the pass-through word.
- After issuing read L-1, go to DRAIN.

DRAIN:
- One cycle.
- Final write: dst + L-1, we = 1.
- Then go to FIN.

FIN:
- done = 1 and busy = 0 for one cycle.
- All we = 0.
- Return to IDLE.

Timing and concurrency rules:
- Latency for L ≥ 1: busy is high for L+1 cycles; done appears in cycle L+1 after the start-sampling edge.
- In SAVE mode the disk is never read, and vice versa.
- Exactly L writes, at strictly increasing destination addresses; never a duplicate or gap.
- start while busy is ignored; the in-flight transfer is unaffected.
- Overlapping source and destination is allowed only across different devices (always true by construction).

Decomposition:
- Shared package holds:
  - dir encodings DIR_LOAD=0, DIR_SAVE=1;
  - state encoding (IDLE, XFER, DRAIN, FIN);
  - DISK_SIZE and MEM_SIZE defaults, shared with the disk and memory modules.
- One natural sub-module, xfer_bounds_check: combinational range check producing the reject condition. Everything else stays in one module.

Test Plan:
- LOAD, src=0, dst=0, length=47, disk preloaded with the boot image → mem[0..46] equals disk[0..46]; mem_we high exactly 47 cycles; done 48 cycles after start; busy low afterwards.
- SAVE, src=100, dst=120, length=4, mem[100..103] = 0xA,0xB,0xC,0xD → disk[120..123] holds those values; disk[119] and disk[124] unchanged; mem_we never asserted.
- LOAD, src=140, length=11 (140+11 > 150) → err pulse the next cycle; busy, disk_we and mem_we stay 0; a following valid command completes normally.
- length=0 → done pulse, no we asserted, no address change; second start asserted mid-transfer with length=5 → ignored, only the first command's words are written.
- rst_n pulled low at XFER cycle 3 of a 10-word LOAD → all outputs 0 immediately; only mem[dst..dst+2] written; after release, a fresh start=1 runs correctly.
